// File: rtl/cdc_fifo_2phase_pkg.sv
// Shared definitions for the split 2-phase CDC FIFO halves: pointer sizing
// helpers, pointer constants and the toggle-transmitter state type.
package cdc_fifo_2phase_pkg;

  // Pointer carries one extra wrap bit beyond the storage index.
  function automatic int unsigned ptr_width(input int unsigned log_depth);
    return log_depth + 32'd1;
  endfunction

  // Pointer distance (write XOR read) that marks a full FIFO.
  function automatic int unsigned ptr_full(input int unsigned log_depth);
    return 32'd1 << log_depth;
  endfunction

  // Pointer value of an empty, freshly reset FIFO.
  localparam int unsigned PtrEmpty = 0;

  // Toggle transmitter: idle when its request equals the synchronized ack.
  typedef enum logic {
    TxIdle = 1'b0,
    TxBusy = 1'b1
  } tx_state_e;

endpackage

// File: rtl/cdc_2phase_tx.sv
// 2-phase (toggle) transmitter for a multi-bit value crossing into another
// clock domain. Whenever the local value differs from the last value sent and
// no handshake is outstanding, it registers the value and toggles req; the data
// register then holds until the toggled ack comes back through the synchronizer.
// Changes made while a handshake is outstanding coalesce into the next launch.
//
// Ports:
//   clk_i, rst_ni   local clock, asynchronous active-low reset
//   data_i          local value to publish (WIDTH bits)
//   async_data_o    registered published value, stable while req is unacked
//   async_req_o     request toggle to the remote domain
//   async_ack_i     acknowledge toggle from the remote domain (asynchronous)
module cdc_2phase_tx
  import cdc_fifo_2phase_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] async_data_o,
  output logic             async_req_o,
  input  logic             async_ack_i
);

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_sync;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [WIDTH-1:0]       sent_q, sent_d;
  tx_state_e              state;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // Ack synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  // Handshake state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      data_q <= '0;
      sent_q <= '0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
      sent_q <= sent_d;
    end
  end

  // Launch decision; the state is implied by req vs. synchronized ack.
  always_comb begin
    state  = (req_q == ack_sync) ? TxIdle : TxBusy;
    req_d  = req_q;
    data_d = data_q;
    sent_d = sent_q;
    unique case (state)
      TxIdle: begin
        if (data_i != sent_q) begin
          data_d = data_i;
          sent_d = data_i;
          req_d  = ~req_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign async_data_o = data_q;
  assign async_req_o  = req_q;

endmodule

// File: rtl/cdc_fifo_2phase_src.sv
// Source-domain half of a split 2-phase CDC FIFO. Holds the storage and the
// write pointer, publishes the write pointer through a toggle transmitter and
// receives the remote read pointer through a toggle receiver.
//
// Ports:
//   src_rst_ni, src_clk_i     asynchronous active-low reset, source clock
//   src_data_i, src_valid_i   payload in and its valid
//   src_ready_o               FIFO not full
//   async_data_o              flattened storage, entry i at [i*$bits(T) +: $bits(T)]
//   async_wptr_data_o/_req_o  published write pointer and its request toggle
//   async_wptr_ack_i          write-pointer acknowledge toggle from remote half
//   async_rptr_data_i/_req_i  remote read pointer and its request toggle
//   async_rptr_ack_o          read-pointer acknowledge toggle
module cdc_fifo_2phase_src
  import cdc_fifo_2phase_pkg::*;
#(
  parameter type         T           = logic,
  parameter int unsigned LOG_DEPTH   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                src_rst_ni,
  input  logic                                src_clk_i,
  input  logic [$bits(T)-1:0]                 src_data_i,
  input  logic                                src_valid_i,
  output logic                                src_ready_o,
  output logic [(2**LOG_DEPTH)*$bits(T)-1:0]  async_data_o,
  output logic [LOG_DEPTH:0]                  async_wptr_data_o,
  output logic                                async_wptr_req_o,
  input  logic                                async_wptr_ack_i,
  input  logic [LOG_DEPTH:0]                  async_rptr_data_i,
  input  logic                                async_rptr_req_i,
  output logic                                async_rptr_ack_o
);

  localparam int unsigned DataW = $bits(T);
  localparam int unsigned Depth = 32'd1 << LOG_DEPTH;
  localparam int unsigned PtrW  = ptr_width(LOG_DEPTH);
  localparam logic [PtrW-1:0] PtrFull = PtrW'(ptr_full(LOG_DEPTH));
  localparam logic [PtrW-1:0] PtrZero = PtrW'(PtrEmpty);

  if (LOG_DEPTH < 1) begin : gen_bad_depth
    $error("cdc_fifo_2phase_src: LOG_DEPTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : gen_bad_sync
    $error("cdc_fifo_2phase_src: SYNC_STAGES must be >= 2");
  end

  logic [Depth-1:0][DataW-1:0] mem_q;
  logic [PtrW-1:0]             wptr_q;
  logic [PtrW-1:0]             rptr_q;
  logic [SYNC_STAGES-1:0]      rptr_req_sync_q;
  logic                        rptr_req_sync;
  logic                        rptr_ack_q;
  logic                        push_c;

  // Full when pointers differ only in the wrap bit; registers only, no valid path.
  assign src_ready_o = ((wptr_q ^ rptr_q) != PtrFull);
  assign push_c      = src_valid_i && src_ready_o;

  // Storage write and write-pointer advance on the same edge.
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      mem_q  <= '0;
      wptr_q <= PtrZero;
    end else if (push_c) begin
      mem_q[wptr_q[LOG_DEPTH-1:0]] <= src_data_i;
      wptr_q                       <= wptr_q + PtrW'(1);
    end
  end

  // Read-pointer receiver: remote data is held stable while its req is unacked.
  assign rptr_req_sync = rptr_req_sync_q[SYNC_STAGES-1];

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      rptr_req_sync_q <= '0;
      rptr_q          <= PtrZero;
      rptr_ack_q      <= 1'b0;
    end else begin
      rptr_req_sync_q <= {rptr_req_sync_q[SYNC_STAGES-2:0], async_rptr_req_i};
      if (rptr_req_sync != rptr_ack_q) begin
        rptr_q     <= async_rptr_data_i;
        rptr_ack_q <= ~rptr_ack_q;
      end
    end
  end

  // Write-pointer publisher; launches one edge after the push that moved it.
  cdc_2phase_tx #(
    .WIDTH       (PtrW),
    .SYNC_STAGES (SYNC_STAGES)
  ) i_wptr_tx (
    .clk_i        (src_clk_i),
    .rst_ni       (src_rst_ni),
    .data_i       (wptr_q),
    .async_data_o (async_wptr_data_o),
    .async_req_o  (async_wptr_req_o),
    .async_ack_i  (async_wptr_ack_i)
  );

  assign async_data_o     = mem_q;
  assign async_rptr_ack_o = rptr_ack_q;

endmodule

// File: tb/tb_cdc_fifo_2phase_src.sv
// Bench for cdc_fifo_2phase_src (LOG_DEPTH=2, SYNC_STAGES=2, 8-bit payload).
// The bench plays the destination half: it acks write-pointer launches after a
// fixed delay and returns read pointers. Stimulus queues the expected published
// pointers and stored entries; a monitor checks them on every req toggle.
module tb_cdc_fifo_2phase_src;

  localparam int unsigned LD    = 2;
  localparam int unsigned SS    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 3;

  typedef struct packed {
    logic [LD-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [DW-1:0]         src_data = '0;
  logic                  src_valid = 1'b0;
  logic                  src_ready;
  logic [DEPTH*DW-1:0]   async_data;
  logic [PW-1:0]         wptr_data;
  logic                  wptr_req;
  logic                  wptr_ack = 1'b0;
  logic [PW-1:0]         rptr_data = '0;
  logic                  rptr_req = 1'b0;
  logic                  rptr_ack;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] exp_pub[$];
  ent_t          exp_ent[$];
  logic [PW-1:0] mw = '0;
  logic [PW-1:0] mr = '0;
  logic [PW-1:0] last_pub = '0;

  always #5 clk = ~clk;

  cdc_fifo_2phase_src #(
    .T           (logic [DW-1:0]),
    .LOG_DEPTH   (LD),
    .SYNC_STAGES (SS)
  ) dut (
    .src_rst_ni        (rst_n),
    .src_clk_i         (clk),
    .src_data_i        (src_data),
    .src_valid_i       (src_valid),
    .src_ready_o       (src_ready),
    .async_data_o      (async_data),
    .async_wptr_data_o (wptr_data),
    .async_wptr_req_o  (wptr_req),
    .async_wptr_ack_i  (wptr_ack),
    .async_rptr_data_i (rptr_data),
    .async_rptr_req_i  (rptr_req),
    .async_rptr_ack_o  (rptr_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] entry(input int i);
    return async_data[i*DW +: DW];
  endfunction

  // Destination-side ack: mirror req five cycles after it changes.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (wptr_req != wptr_ack)) begin
        cnt++;
        if (cnt == 5) begin
          wptr_ack = wptr_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: each req toggle must carry the next expected pointer, and every
  // entry it newly covers must already hold the pushed payload.
  initial begin
    logic prev_req;
    ent_t e;
    logic [PW-1:0] ev;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        last_pub = '0;
      end else if (wptr_req != prev_req) begin
        prev_req = wptr_req;
        if (exp_pub.size() == 0) begin
          n_checks++;
          $display("FAIL wptr_launch: got pointer %0d, expected no launch", wptr_data);
        end else begin
          ev = exp_pub.pop_front();
          check("wptr_launch", 32'(wptr_data), 32'(ev));
        end
        for (int k = 0; k < 8 && last_pub != wptr_data; k++) begin
          if (exp_ent.size() == 0) begin
            n_checks++;
            $display("FAIL entry_cover: got pointer %0d, expected no uncovered entry", wptr_data);
            break;
          end
          e = exp_ent.pop_front();
          check("entry_at_publish", 32'(entry(int'(e.idx))), 32'(e.data));
          last_pub = last_pub + PW'(1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Offer one payload for one edge; ready expectation comes from the occupancy model.
  task automatic push(input logic [DW-1:0] d);
    logic [PW-1:0] occ;
    logic          exp_rdy;
    occ       = mw - mr;
    exp_rdy   = (occ != PW'(DEPTH));
    src_data  = d;
    src_valid = 1'b1;
    check("ready_at_offer", 32'(src_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      exp_ent.push_back(ent_t'{mw[LD-1:0], d});
      mw = mw + PW'(1);
    end
    @(posedge clk);
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  // Return a read pointer with a req toggle; expect the ack after 2-3 edges.
  task automatic send_rptr(input logic [PW-1:0] v);
    int n;
    logic [PW-1:0] occ;
    rptr_data = v;
    rptr_req  = ~rptr_req;
    n = 0;
    while ((rptr_ack != rptr_req) && (n < 10)) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("rptr_ack", 32'(rptr_ack), 32'(rptr_req));
    check("rptr_ack_latency_2_to_3", 32'(n >= 2 && n <= 3), 32'd1);
    mr  = v;
    occ = mw - mr;
    check("ready_after_rptr", 32'(src_ready), 32'(occ != PW'(DEPTH)));
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n     = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    wptr_ack  = 1'b0;
    rptr_req  = 1'b0;
    rptr_data = '0;
    mw = '0;
    mr = '0;
    exp_pub.delete();
    exp_ent.delete();
    tick(3);
    check("rst_ready", 32'(src_ready), 32'd1);
    check("rst_async_data", async_data, 32'd0);
    check("rst_wptr_data", 32'(wptr_data), 32'd0);
    check("rst_wptr_req", 32'(wptr_req), 32'd0);
    check("rst_rptr_ack", 32'(rptr_ack), 32'd0);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_all();

    // Single push: stored on its edge, published on the next.
    exp_pub.push_back(PW'(1));
    push(8'hA5);
    check("entry0_after_push", 32'(entry(0)), 32'hA5);
    check("req_before_launch", 32'(wptr_req), 32'd0);
    tick(1);
    check("req_at_launch", 32'(wptr_req), 32'd1);
    check("wptr_at_launch", 32'(wptr_data), 32'd1);

    // Three pushes while busy coalesce into one launch of 4; FIFO is then full.
    exp_pub.push_back(PW'(4));
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("ready_when_full", 32'(src_ready), 32'd0);
    push(8'h55);
    push(8'h56);
    push(8'h57);
    tick(25);
    check("wptr_stays_4", 32'(wptr_data), 32'd4);
    check("req_back_to_0", 32'(wptr_req), 32'd0);
    check("still_full", 32'(src_ready), 32'd0);

    // Read pointer 2 frees exactly two slots.
    send_rptr(PW'(2));
    exp_pub.push_back(PW'(5));
    exp_pub.push_back(PW'(6));
    push(8'h66);
    push(8'h77);
    push(8'h88);
    tick(25);
    check("wptr_after_refill", 32'(wptr_data), 32'd6);
    check("entry0_refill", 32'(entry(0)), 32'h66);
    check("entry1_refill", 32'(entry(1)), 32'h77);

    // Wrap: eight pushes each drained by a read-pointer return.
    reset_all();
    for (int i = 0; i < 8; i++) begin
      exp_pub.push_back(PW'(i + 1));
      push(8'(8'h10 + i));
      tick(15);
      send_rptr(mw);
    end
    check("wptr_wrapped", 32'(wptr_data), 32'd0);
    exp_pub.push_back(PW'(1));
    push(8'h99);
    check("entry0_ninth_push", 32'(entry(0)), 32'h99);
    tick(15);
    check("all_launches_seen", 32'(exp_pub.size()), 32'd0);
    check("all_entries_seen", 32'(exp_ent.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
